// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - core-side and memory-side signals of the instruction fetch stage.
interface inst_fetch_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] pc;
  logic                  flush;
  logic [31:0]           inst;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic                  inst_valid;
  logic                  inst_err;
  logic                  inst_ready;
  logic                  mem_req_valid;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_req_ready;
  logic                  mem_resp_valid;
  logic [31:0]           mem_resp_data;
  logic                  mem_resp_err;

  // master is the fetch stage; slave is the core plus instruction memory around it
  modport master (
    input  pc, flush, inst_ready, mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
    output inst, inst_pc, inst_valid, inst_err, mem_req_valid, mem_req_addr
  );

  modport slave (
    output pc, flush, inst_ready, mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
    input  inst, inst_pc, inst_valid, inst_err, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - single-outstanding instruction fetch stage feeding the RV32IM core.
module inst_fetch #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input logic          clk,
  input logic          global_rst,
  inst_fetch_if.master bus
);
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t                state;
  state_t                state_next;
  logic                  discard;
  logic                  discard_next;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic [31:0]           inst_q;
  logic [ADDR_WIDTH-1:0] inst_pc_q;
  logic                  inst_err_q;
  logic                  load_pc;
  logic                  load_fault;
  logic                  load_resp;
  logic                  pc_misaligned;

  assign pc_misaligned = (bus.pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (global_rst) begin
      state   <= IDLE;
      discard <= 1'b0;
    end else begin
      state   <= state_next;
      discard <= discard_next;
    end
  end

  // A flushed fetch still completes its memory handshake; discard marks its response as stale.
  always_comb begin
    state_next   = state;
    discard_next = discard;
    load_pc      = 1'b0;
    load_fault   = 1'b0;
    load_resp    = 1'b0;
    case (state)
      IDLE: begin
        load_pc = 1'b1;
        if (pc_misaligned) begin
          load_fault = 1'b1;
          state_next = HOLD;
        end else begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (bus.flush) discard_next = 1'b1;
        if (bus.mem_req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (bus.mem_resp_valid) begin
          discard_next = 1'b0;
          if (discard || bus.flush) begin
            state_next = IDLE;
          end else begin
            load_resp  = 1'b1;
            state_next = HOLD;
          end
        end else if (bus.flush) begin
          discard_next = 1'b1;
        end
      end
      HOLD: begin
        if (bus.flush || bus.inst_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (global_rst) begin
      req_pc     <= '0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      inst_err_q <= 1'b0;
    end else begin
      if (load_pc) req_pc <= bus.pc;
      if (load_fault) begin
        inst_q     <= NOP_INST;
        inst_pc_q  <= bus.pc;
        inst_err_q <= 1'b1;
      end else if (load_resp) begin
        inst_q     <= bus.mem_resp_err ? NOP_INST : bus.mem_resp_data;
        inst_pc_q  <= req_pc;
        inst_err_q <= bus.mem_resp_err;
      end
    end
  end

  assign bus.inst          = inst_q;
  assign bus.inst_pc       = inst_pc_q;
  assign bus.inst_err      = inst_err_q;
  assign bus.inst_valid    = (state == HOLD);
  assign bus.mem_req_valid = (state == REQ);
  assign bus.mem_req_addr  = {req_pc[ADDR_WIDTH-1:2], 2'b00};
endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed and randomized checks of inst_fetch against a behavioural core/memory model.
module tb_inst_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic global_rst;
  int   total = 0;
  int   bad   = 0;

  inst_fetch_if #(.ADDR_WIDTH(32)) bus ();

  inst_fetch dut (
    .clk        (clk),
    .global_rst (global_rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A5B;
  endfunction

  function automatic logic mem_fault(input logic [31:0] a);
    return (a[6:2] == 5'h0B);
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_idle_inputs();
    bus.pc             = '0;
    bus.flush          = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    bus.mem_resp_err   = 1'b0;
  endtask

  task automatic do_reset();
    step();
    global_rst = 1'b1;
    drive_idle_inputs();
    step();
    global_rst = 1'b0;
  endtask

  task automatic test_reset();
    global_rst = 1'b1;
    drive_idle_inputs();
    bus.pc = 32'h8000_0000;
    step();
    step();
    total++;
    if ({bus.inst_valid, bus.inst_err, bus.mem_req_valid, bus.inst, bus.inst_pc, bus.mem_req_addr} !== '0)
      begin bad++; $display("FAIL reset_outputs: got valid=%0b err=%0b req=%0b inst=%h pc=%h addr=%h want all 0",
        bus.inst_valid, bus.inst_err, bus.mem_req_valid, bus.inst, bus.inst_pc, bus.mem_req_addr); end
    global_rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    bus.pc = 32'h8000_0000;
    bus.mem_req_ready = 1'b1;
    step();
    total++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h8000_0000)
      begin bad++; $display("FAIL basic_req: got valid=%0b addr=%h want 1 80000000", bus.mem_req_valid, bus.mem_req_addr); end
    step();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h0010_0093;
    total++;
    if (bus.inst_valid !== 1'b0 || bus.mem_req_valid !== 1'b0)
      begin bad++; $display("FAIL basic_wait: got inst_valid=%0b req=%0b want 0 0", bus.inst_valid, bus.mem_req_valid); end
    step();
    bus.mem_resp_valid = 1'b0;
    total++;
    if ({bus.inst_valid, bus.inst_err, bus.inst, bus.inst_pc} !== {1'b1, 1'b0, 32'h0010_0093, 32'h8000_0000})
      begin bad++; $display("FAIL basic_inst: got valid=%0b err=%0b inst=%h pc=%h want 1 0 00100093 80000000",
        bus.inst_valid, bus.inst_err, bus.inst, bus.inst_pc); end
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    total++;
    if (bus.inst_valid !== 1'b0)
      begin bad++; $display("FAIL basic_accept: got inst_valid=%0b want 0", bus.inst_valid); end
  endtask

  task automatic test_req_stall();
    do_reset();
    bus.pc = 32'h8000_0100;
    step();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h8000_0100)
        begin bad++; $display("FAIL stall_req[%0d]: got valid=%0b addr=%h want 1 80000100", i, bus.mem_req_valid, bus.mem_req_addr); end
      if (i < 4) step();
    end
    bus.mem_req_ready = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (bus.mem_req_valid !== 1'b0)
        begin bad++; $display("FAIL stall_single[%0d]: got req_valid=%0b want 0", i, bus.mem_req_valid); end
      step();
    end
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h1234_5678;
    step();
    bus.mem_resp_valid = 1'b0;
    total++;
    if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, 32'h1234_5678, 32'h8000_0100})
      begin bad++; $display("FAIL stall_inst: got valid=%0b inst=%h pc=%h want 1 12345678 80000100",
        bus.inst_valid, bus.inst, bus.inst_pc); end
  endtask

  task automatic test_hold_stall();
    do_reset();
    bus.pc = 32'h8000_0200;
    bus.mem_req_ready = 1'b1;
    step();
    step();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hCAFE_0001;
    step();
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({bus.inst_valid, bus.inst, bus.inst_pc, bus.mem_req_valid} !== {1'b1, 32'hCAFE_0001, 32'h8000_0200, 1'b0})
        begin bad++; $display("FAIL hold_stable[%0d]: got valid=%0b inst=%h pc=%h req=%0b want 1 cafe0001 80000200 0",
          i, bus.inst_valid, bus.inst, bus.inst_pc, bus.mem_req_valid); end
      step();
    end
    bus.inst_ready = 1'b1;
    bus.pc = 32'h8000_0204;
    step();
    bus.inst_ready = 1'b0;
    total++;
    if (bus.inst_valid !== 1'b0 || bus.mem_req_valid !== 1'b0)
      begin bad++; $display("FAIL hold_release: got valid=%0b req=%0b want 0 0", bus.inst_valid, bus.mem_req_valid); end
    step();
    total++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h8000_0204)
      begin bad++; $display("FAIL hold_refetch: got valid=%0b addr=%h want 1 80000204", bus.mem_req_valid, bus.mem_req_addr); end
  endtask

  task automatic test_flush();
    do_reset();
    bus.pc = 32'h8000_0300;
    bus.mem_req_ready = 1'b1;
    step();
    step();
    bus.flush = 1'b1;
    bus.pc    = 32'h8000_0010;
    step();
    bus.flush = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hBAD0_0BAD;
    step();
    bus.mem_resp_valid = 1'b0;
    total++;
    if (bus.inst_valid !== 1'b0 || bus.mem_req_valid !== 1'b0)
      begin bad++; $display("FAIL flush_drop: got valid=%0b req=%0b want 0 0", bus.inst_valid, bus.mem_req_valid); end
    step();
    total++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h8000_0010 || bus.inst_valid !== 1'b0)
      begin bad++; $display("FAIL flush_refetch: got req=%0b addr=%h valid=%0b want 1 80000010 0",
        bus.mem_req_valid, bus.mem_req_addr, bus.inst_valid); end
    step();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h0000_1111;
    bus.flush = 1'b1;
    bus.pc    = 32'h8000_0900;
    step();
    bus.mem_resp_valid = 1'b0;
    bus.flush = 1'b0;
    total++;
    if (bus.inst_valid !== 1'b0)
      begin bad++; $display("FAIL flush_same_cycle: got valid=%0b want 0", bus.inst_valid); end
    step();
    step();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h0000_2222;
    step();
    bus.mem_resp_valid = 1'b0;
    total++;
    if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, 32'h0000_2222, 32'h8000_0900})
      begin bad++; $display("FAIL flush_next_inst: got valid=%0b inst=%h pc=%h want 1 00002222 80000900",
        bus.inst_valid, bus.inst, bus.inst_pc); end
    bus.flush      = 1'b1;
    bus.inst_ready = 1'b1;
    bus.pc         = 32'h8000_0700;
    step();
    bus.flush      = 1'b0;
    bus.inst_ready = 1'b0;
    total++;
    if (bus.inst_valid !== 1'b0)
      begin bad++; $display("FAIL flush_hold: got valid=%0b want 0", bus.inst_valid); end
    step();
    total++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h8000_0700)
      begin bad++; $display("FAIL flush_hold_refetch: got req=%0b addr=%h want 1 80000700", bus.mem_req_valid, bus.mem_req_addr); end
  endtask

  task automatic test_faults();
    do_reset();
    bus.pc = 32'h8000_0002;
    bus.mem_req_ready = 1'b1;
    step();
    total++;
    if ({bus.mem_req_valid, bus.inst_valid, bus.inst_err, bus.inst, bus.inst_pc} !== {1'b0, 1'b1, 1'b1, NOP, 32'h8000_0002})
      begin bad++; $display("FAIL misaligned: got req=%0b valid=%0b err=%0b inst=%h pc=%h want 0 1 1 00000013 80000002",
        bus.mem_req_valid, bus.inst_valid, bus.inst_err, bus.inst, bus.inst_pc); end
    bus.inst_ready = 1'b1;
    bus.pc = 32'h8000_0400;
    step();
    bus.inst_ready = 1'b0;
    step();
    step();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_err   = 1'b1;
    bus.mem_resp_data  = 32'hDEAD_BEEF;
    step();
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_err   = 1'b0;
    total++;
    if ({bus.inst_valid, bus.inst_err, bus.inst, bus.inst_pc} !== {1'b1, 1'b1, NOP, 32'h8000_0400})
      begin bad++; $display("FAIL resp_err: got valid=%0b err=%0b inst=%h pc=%h want 1 1 00000013 80000400",
        bus.inst_valid, bus.inst_err, bus.inst, bus.inst_pc); end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    bus.pc = 32'h8000_0500;
    bus.mem_req_ready = 1'b1;
    step();
    step();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h5555_AAAA;
    step();
    bus.mem_resp_valid = 1'b0;
    bus.inst_ready = 1'b1;
    bus.pc = 32'h8000_0504;
    step();
    bus.inst_ready = 1'b0;
    step();
    step();
    global_rst = 1'b1;
    step();
    total++;
    if ({bus.inst_valid, bus.inst_err, bus.mem_req_valid, bus.inst, bus.inst_pc, bus.mem_req_addr} !== '0)
      begin bad++; $display("FAIL reset_in_wait: got valid=%0b err=%0b req=%0b inst=%h pc=%h addr=%h want all 0",
        bus.inst_valid, bus.inst_err, bus.mem_req_valid, bus.inst, bus.inst_pc, bus.mem_req_addr); end
    global_rst = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h7777_7777;
    step();
    bus.mem_resp_valid = 1'b0;
    total++;
    if (bus.inst_valid !== 1'b0 || bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h8000_0504)
      begin bad++; $display("FAIL late_resp: got valid=%0b req=%0b addr=%h want 0 1 80000504",
        bus.inst_valid, bus.mem_req_valid, bus.mem_req_addr); end
  endtask

  // Core model: pc moves only on accept or flush, so any presented instruction must belong to the current pc.
  task automatic test_random();
    logic [31:0] core_pc;
    logic [31:0] pend_addr;
    logic [31:0] prev_addr;
    logic [31:0] exp_inst;
    logic        exp_err;
    bit          pend;
    bit          prev_stall;
    int          cnt;
    int          quiet;
    int          accepts;
    do_reset();
    core_pc    = 32'h8000_1000;
    bus.pc     = core_pc;
    pend       = 0;
    prev_stall = 0;
    prev_addr  = '0;
    pend_addr  = '0;
    cnt        = 0;
    quiet      = 0;
    accepts    = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = $urandom;
      bus.mem_resp_err   = 1'($urandom_range(0, 1));
      if (pend) begin
        if (cnt == 0) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_data  = mem_word(pend_addr);
          bus.mem_resp_err   = mem_fault(pend_addr);
          pend = 0;
        end else begin
          cnt--;
        end
      end
      if (prev_stall) begin
        total++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== prev_addr)
          begin bad++; $display("FAIL rnd_req_stable @%0d: got valid=%0b addr=%h want 1 %h", cyc, bus.mem_req_valid, bus.mem_req_addr, prev_addr); end
      end
      if (bus.mem_req_valid) begin
        total++;
        if (pend || bus.mem_req_addr[1:0] !== 2'b00)
          begin bad++; $display("FAIL rnd_req_single @%0d: got outstanding=%0b addr=%h want 0 aligned", cyc, pend, bus.mem_req_addr); end
      end
      bus.mem_req_ready = ($urandom_range(0, 3) != 0);
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        pend      = 1;
        cnt       = $urandom_range(0, 2);
        pend_addr = bus.mem_req_addr;
      end
      prev_stall = bus.mem_req_valid && !bus.mem_req_ready;
      prev_addr  = bus.mem_req_addr;

      bus.flush      = 1'b0;
      bus.inst_ready = 1'b0;
      if (bus.inst_valid) begin
        quiet = 0;
        if (core_pc[1:0] != 2'b00 || mem_fault(core_pc)) begin
          exp_inst = NOP;
          exp_err  = 1'b1;
        end else begin
          exp_inst = mem_word(core_pc);
          exp_err  = 1'b0;
        end
        total++;
        if (bus.inst !== exp_inst || bus.inst_err !== exp_err || bus.inst_pc !== core_pc)
          begin bad++; $display("FAIL rnd_inst @%0d: got inst=%h err=%0b pc=%h want %h %0b %h",
            cyc, bus.inst, bus.inst_err, bus.inst_pc, exp_inst, exp_err, core_pc); end
      end else begin
        quiet++;
      end
      if (quiet > 100) begin
        total++;
        bad++;
        $display("FAIL rnd_progress @%0d: got %0d cycles without inst_valid want <=100", cyc, quiet);
        break;
      end
      if ($urandom_range(0, 31) == 0) begin
        bus.flush      = 1'b1;
        bus.inst_ready = 1'($urandom_range(0, 1));
        core_pc = {core_pc[31:2], 2'b00} + 32'(4 * $urandom_range(1, 64)) + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      end else if (bus.inst_valid && $urandom_range(0, 2) != 0) begin
        bus.inst_ready = 1'b1;
        accepts++;
        if ($urandom_range(0, 5) == 0)
          core_pc = {core_pc[31:2], 2'b00} + 32'(4 * $urandom_range(1, 64)) + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
        else
          core_pc = {core_pc[31:2], 2'b00} + 32'd4;
      end else if (!bus.inst_valid) begin
        bus.inst_ready = 1'($urandom_range(0, 1));
      end
      bus.pc = core_pc;
    end
    total++;
    if (accepts < 100)
      begin bad++; $display("FAIL rnd_accepts: got %0d accepted instructions want >=100", accepts); end
  endtask

  initial begin
    global_rst = 1'b1;
    drive_idle_inputs();
    test_reset();
    test_basic();
    test_req_stall();
    test_hold_stall();
    test_flush();
    test_faults();
    test_reset_in_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
